// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the IF stage.
//
// Lookup is combinational on the fetch PC; training comes from EX with the
// resolved outcome and target. Index = pc[INDEX_BITS+1:2], tag = upper PC bits.
// Writes land at posedge clk. A lookup of the entry being written in the same
// cycle sees the pre-edge contents (no bypass).
//
// Optional feature: define BTB_2BIT_CTR_EN to add a 2-bit saturating counter
// per entry. A hit then also needs ctr[1] set, and a not-taken match decrements
// the counter instead of invalidating the entry.
//
// Ports:
//   clk              clock, all state updates on posedge
//   reset            asynchronous active-low reset; clears valid (and counters)
//   pc_if            fetch PC to look up
//   pc_ex            PC of the instruction in EX
//   branch_taken_ex  EX resolved a taken control transfer
//   target_addr_ex   resolved target of the EX instruction
//   predicted_target predicted next PC (zero when no hit)
//   hit              prediction valid for pc_if
module branch_target_buffer #(
    parameter int unsigned ENTRIES    = 64,
    parameter int unsigned ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] pc_if,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic                  branch_taken_ex,
    input  logic [ADDR_WIDTH-1:0] target_addr_ex,
    output logic [ADDR_WIDTH-1:0] predicted_target,
    output logic                  hit
);

    localparam int unsigned INDEX_BITS = $clog2(ENTRIES);
    localparam int unsigned TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;

    logic                  valid_q  [ENTRIES];
    logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
    logic [ADDR_WIDTH-1:0] target_q [ENTRIES];

    logic [INDEX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0]   if_tag, ex_tag;
    logic                  ex_match;
    logic                  valid_d;

    // Instruction-alignment bits take no part in indexing or tagging.
    logic unused_pc_low;
    assign unused_pc_low = ^{pc_if[1:0], pc_ex[1:0]};

    assign if_idx = pc_if[INDEX_BITS+1:2];
    assign if_tag = pc_if[ADDR_WIDTH-1:INDEX_BITS+2];
    assign ex_idx = pc_ex[INDEX_BITS+1:2];
    assign ex_tag = pc_ex[ADDR_WIDTH-1:INDEX_BITS+2];

    assign ex_match = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

`ifdef BTB_2BIT_CTR_EN
    logic [1:0] ctr_q [ENTRIES];
    logic [1:0] ctr_d;

    always_comb begin
        valid_d = valid_q[ex_idx];
        ctr_d   = ctr_q[ex_idx];
        if (branch_taken_ex) begin
            valid_d = 1'b1;
            if (ex_match) begin
                ctr_d = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
            end else begin
                ctr_d = 2'b10;  // fresh allocation starts weakly taken
            end
        end else if (ex_match) begin
            // Entry stays valid; only confidence drops.
            ctr_d = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'd0;
            end
        end else begin
            valid_q[ex_idx] <= valid_d;
            ctr_q[ex_idx]   <= ctr_d;
        end
    end

    assign hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && ctr_q[if_idx][1];
`else
    always_comb begin
        valid_d = valid_q[ex_idx];
        if (branch_taken_ex) begin
            valid_d = 1'b1;
        end else if (ex_match) begin
            valid_d = 1'b0;  // not-taken on a matching entry invalidates it
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            valid_q[ex_idx] <= valid_d;
        end
    end

    assign hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
`endif

    // Tags and targets are qualified by valid, so they need no reset. A taken
    // branch always (re)writes them; on alias the old entry is replaced.
    always_ff @(posedge clk) begin
        if (branch_taken_ex) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= target_addr_ex;
        end
    end

    assign predicted_target = hit ? target_q[if_idx] : '0;

endmodule

// File: tb/tb_branch_target_buffer.sv
module tb_branch_target_buffer;

    localparam int unsigned ENTRIES = 64;
    localparam int unsigned AW      = 64;
    localparam int unsigned IB      = $clog2(ENTRIES);

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc_if, pc_ex, target_addr_ex, predicted_target;
    logic          branch_taken_ex, hit;

    int checks = 0;
    int passed = 0;

    branch_target_buffer #(
        .ENTRIES    (ENTRIES),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .pc_if            (pc_if),
        .pc_ex            (pc_ex),
        .branch_taken_ex  (branch_taken_ex),
        .target_addr_ex   (target_addr_ex),
        .predicted_target (predicted_target),
        .hit              (hit)
    );

    always #5 clk = ~clk;

    // Behavioural model: a table indexed by word address modulo ENTRIES.
    bit            m_valid [ENTRIES];
    logic [AW-1:0] m_tag   [ENTRIES];
    logic [AW-1:0] m_tgt   [ENTRIES];
    int            m_ctr   [ENTRIES];

    function automatic int m_idx(logic [AW-1:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [AW-1:0] m_tagof(logic [AW-1:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    function automatic bit m_hit(logic [AW-1:0] pc);
        int i = m_idx(pc);
        bit h = m_valid[i] && (m_tag[i] == m_tagof(pc));
`ifdef BTB_2BIT_CTR_EN
        h = h && (m_ctr[i] >= 2);
`endif
        return h;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 0;
        end
    endtask

    task automatic m_update();
        int i   = m_idx(pc_ex);
        bit mat = m_valid[i] && (m_tag[i] == m_tagof(pc_ex));
        if (branch_taken_ex) begin
`ifdef BTB_2BIT_CTR_EN
            m_ctr[i] = mat ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : 2;
`endif
            m_valid[i] = 1;
            m_tag[i]   = m_tagof(pc_ex);
            m_tgt[i]   = target_addr_ex;
        end else if (mat) begin
`ifdef BTB_2BIT_CTR_EN
            m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
`else
            m_valid[i] = 0;
`endif
        end
    endtask

    task automatic chk(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    // Compare the DUT against the model for the current pc_if.
    task automatic cmp_model();
        bit h = m_hit(pc_if);
        chk("model_hit", {63'd0, hit}, {63'd0, h});
        chk("model_target", predicted_target, h ? m_tgt[m_idx(pc_if)] : '0);
    endtask

    // Set pc_if, compare with the model and with literal expectations.
    task automatic look(string name, logic [AW-1:0] pc, bit exp_hit, logic [AW-1:0] exp_tgt);
        pc_if = pc;
        #1;
        cmp_model();
        chk({name, "_hit"}, {63'd0, hit}, {63'd0, exp_hit});
        chk({name, "_tgt"}, predicted_target, exp_tgt);
    endtask

    task automatic drive(logic [AW-1:0] pc, bit taken, logic [AW-1:0] tgt);
        pc_ex = pc;
        branch_taken_ex = taken;
        target_addr_ex = tgt;
    endtask

    // Advance one cycle: model follows the DUT edge, return at the falling edge.
    task automatic tick();
        @(posedge clk);
        if (reset) m_update();
        @(negedge clk);
    endtask

    initial begin
        m_clear();
        for (int i = 0; i < int'(ENTRIES); i++) begin
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        // Reset held while a taken update is presented.
        reset = 1'b0;
        drive(64'h1000, 1'b1, 64'h2040);
        pc_if = 64'h1000;
        @(negedge clk);
        look("rst_held", 64'h1000, 1'b0, 64'h0);
        tick();
        look("rst_held2", 64'h1000, 1'b0, 64'h0);
        drive(64'h0, 1'b0, 64'h0);
        reset = 1'b1;
        tick();
        look("after_rst", 64'h1000, 1'b0, 64'h0);

        // Train, with same-cycle lookup seeing old contents.
        drive(64'h1000, 1'b1, 64'h2040);
        look("same_cycle", 64'h1000, 1'b0, 64'h0);
        tick();
        drive(64'h0, 1'b0, 64'h0);
        look("trained", 64'h1000, 1'b1, 64'h2040);
        look("neighbour", 64'h1004, 1'b0, 64'h0);

        // Alias replaces the entry.
        drive(64'h1100, 1'b1, 64'h3000);
        tick();
        drive(64'h0, 1'b0, 64'h0);
        look("alias_old", 64'h1000, 1'b0, 64'h0);
        look("alias_new", 64'h1100, 1'b1, 64'h3000);

        // Not-taken: non-matching leaves entry, matching drops the hit.
        drive(64'h1000, 1'b1, 64'h2040);
        tick();
        drive(64'h1100, 1'b0, 64'h0);
        tick();
        look("nt_nomatch", 64'h1000, 1'b1, 64'h2040);
        drive(64'h1000, 1'b0, 64'h0);
        tick();
        drive(64'h0, 1'b0, 64'h0);
        look("nt_match", 64'h1000, 1'b0, 64'h0);

        // Asynchronous reset pulse mid-cycle.
        drive(64'h1000, 1'b1, 64'h2040);
        tick();
        drive(64'h0, 1'b0, 64'h0);
        look("pre_pulse", 64'h1000, 1'b1, 64'h2040);
        reset = 1'b0;
        m_clear();
        look("pulse", 64'h1000, 1'b0, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        look("post_pulse", 64'h1000, 1'b0, 64'h0);

`ifdef BTB_2BIT_CTR_EN
        drive(64'h2000, 1'b1, 64'h4444);
        tick();
        look("ctr2", 64'h2000, 1'b1, 64'h4444);
        drive(64'h2000, 1'b0, 64'h0);
        tick();
        look("ctr1", 64'h2000, 1'b0, 64'h0);
        drive(64'h2000, 1'b1, 64'h4444);
        tick();
        tick();
        look("ctr3", 64'h2000, 1'b1, 64'h4444);
        drive(64'h2000, 1'b0, 64'h0);
        tick();
        drive(64'h0, 1'b0, 64'h0);
        look("ctr3to2", 64'h2000, 1'b1, 64'h4444);
`endif

        // Randomised traffic over a small PC pool so aliasing and hits occur.
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a, b;
            a = 64'h8000_0000 + 64'($urandom_range(0, 3)) * (4 * ENTRIES)
                + 64'($urandom_range(0, 7)) * 4 + 64'($urandom_range(0, 3));
            b = 64'h8000_0000 + 64'($urandom_range(0, 3)) * (4 * ENTRIES)
                + 64'($urandom_range(0, 7)) * 4 + 64'($urandom_range(0, 3));
            drive(a, 1'($urandom_range(0, 1)), {$urandom, $urandom});
            pc_if = b;
            #1;
            cmp_model();
            if ($urandom_range(0, 199) == 0) begin
                reset = 1'b0;
                m_clear();
                #1;
                cmp_model();
                tick();
                reset = 1'b1;
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
